// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the multi-cycle data memory responder.
package data_mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFFS_W = 2;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  // Word index of a byte address, wrapped to the array depth.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned depth);
    return (addr >> OFFS_W) % depth;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// dmem_array: single-port word array, synchronous write, combinational read.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned AW          = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: fixed LATENCY, one outstanding request.
// Optional DMEM_ALIGN_CHECK_EN rejects misaligned or out-of-range addresses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_input_valid,
  input  logic [31:0]       addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] din,
  output logic              mem_ready,
  output logic              is_output_valid,
  output logic [WORD_W-1:0] dout,
  output logic              addr_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;

  logic              resp;
  logic              rw_ok;
  logic              addr_ok;
  logic              accept;
  logic              we;
  logic [WORD_W-1:0] rdata;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (idx_q),
    .wdata(din_q),
    .rdata(rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    we      = 1'b0;

    resp      = (state_q == WAIT) && (cnt_q == 8'd0);
    mem_ready = (state_q == IDLE) || resp;
    rw_ok     = mem_read ^ mem_write;
`ifdef DMEM_ALIGN_CHECK_EN
    addr_ok   = (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
`else
    addr_ok   = 1'b1;
`endif
    accept    = is_input_valid && mem_ready && rw_ok && addr_ok;
    err_d     = is_input_valid && mem_ready && !(rw_ok && addr_ok);

    if ((state_q == WAIT) && (cnt_q != 8'd0)) cnt_d = cnt_q - 8'd1;

    // A store commits at the end of its response cycle unless reset aborts it;
    // the array read in that same cycle still sees the pre-store contents.
    if (resp) begin
      state_d = IDLE;
      we      = wr_q && !reset;
      if (!wr_q) dout_d = rdata;
    end

    if (accept) begin
      state_d = WAIT;
      cnt_d   = 8'(LATENCY - 1);
      idx_d   = IDX_W'(word_index(addr, DEPTH_WORDS));
      wr_d    = mem_write;
      din_d   = din;
    end

    is_output_valid = resp;
    dout            = (resp && !wr_q) ? rdata : dout_q;
    addr_err        = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

endmodule
